// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator and capture blocks.
package pwm_pkg;

    localparam int unsigned PwmWidth = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } pwm_cap_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus one delay flop for
// single-cycle rise/fall strobes.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures rise-to-rise period (minus one) and high time,
// and flags an input that stops toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH          = PwmWidth,
    parameter int unsigned      SYNC_STAGES    = 2,
    parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] meas_period,
    output logic [WIDTH-1:0] meas_duty,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level,
    output logic             busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    localparam logic [WIDTH-1:0] TimeoutLast = TIMEOUT_CYCLES - 1'b1;
    localparam logic [WIDTH-1:0] CntOne      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic level, rise_det, fall_det;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_sig (pwm_in),
        .level     (level),
        .rise      (rise_det),
        .fall      (fall_det)
    );

    pwm_cap_state_t   state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_q, stuck_d;
    logic             expired;

    // cnt is reset by the timeout before it can reach 2^WIDTH-1, so no wrap.
    assign cnt_inc = cnt_q + CntOne;
    assign expired = (cnt_q == TimeoutLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        period_d  = period_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        stuck_d   = stuck_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise_det) begin
                        state_d  = MEASURE;
                        cnt_d    = '0;
                        shadow_d = '0;
                    end else if (expired) begin
                        timeout_d = 1'b1;
                        stuck_d   = level;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    // A rising edge on the last timeout cycle still counts as a period.
                    if (rise_det) begin
                        period_d = cnt_q;
                        duty_d   = shadow_q;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                        shadow_d = '0;
                    end else if (expired) begin
                        timeout_d = 1'b1;
                        stuck_d   = level;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_inc;
                        if (fall_det) begin
                            shadow_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
        end
    end

    assign meas_period = period_q;
    assign meas_duty   = duty_q;
    assign meas_valid  = valid_q;
    assign timeout     = timeout_q;
    assign stuck_level = stuck_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT_CYCLES = 50.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n, enable, pwm_in;
    logic [31:0] meas_period, meas_duty;
    logic        meas_valid, timeout, stuck_level, busy;

    pwm_capture #(
        .WIDTH          (32),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .meas_period (meas_period),
        .meas_duty   (meas_duty),
        .meas_valid  (meas_valid),
        .timeout     (timeout),
        .stuck_level (stuck_level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    int unsigned n_valid = 0, n_timeout = 0, tot_both = 0, tot_wide = 0;
    int unsigned cyc = 0, last_valid_cyc = 0, valid_gap = 0;
    logic        prev_valid = 1'b0, prev_timeout = 1'b0;
    logic [31:0] hist[$];

    always @(negedge clk) begin
        if (meas_valid) begin
            n_valid++;
            hist.push_back(meas_period);
            valid_gap      = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            if (prev_valid) tot_wide++;
        end
        if (timeout) begin
            n_timeout++;
            if (prev_timeout) tot_wide++;
        end
        if (meas_valid && timeout) tot_both++;
        prev_valid   = meas_valid;
        prev_timeout = timeout;
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid   = 0;
        n_timeout = 0;
        hist.delete();
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_wave(input int unsigned h, input int unsigned l, input int unsigned n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            step(h);
            pwm_in = 1'b0;
            step(l);
        end
    endtask

    initial begin
        int unsigned k;
        logic        seen;

        rst_n  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        step(3);
        check_eq("rst_period", meas_period, 0);
        check_eq("rst_duty", meas_duty, 0);
        check_eq("rst_valid", {31'd0, meas_valid}, 0);
        check_eq("rst_timeout", {31'd0, timeout}, 0);
        check_eq("rst_stuck", {31'd0, stuck_level}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);

        // Loopback 3 high / 7 low: first period discarded.
        rst_n  = 1'b1;
        enable = 1'b1;
        step(1);
        check_eq("arm_busy", {31'd0, busy}, 1);
        clear_counts();
        drive_wave(3, 7, 6);
        check_eq("lb_nvalid", n_valid, 5);
        check_eq("lb_period", meas_period, 9);
        check_eq("lb_duty", meas_duty, 3);
        check_eq("lb_gap", valid_gap, 10);
        check_eq("lb_timeout", n_timeout, 0);

        // Period change with one transitional 15-cycle period.
        clear_counts();
        drive_wave(3, 12, 1);
        drive_wave(3, 17, 3);
        check_eq("pc_nvalid", n_valid, 4);
        check_eq("pc_first", hist[0], 9);
        check_eq("pc_trans", hist[1], 14);
        check_eq("pc_steady", hist[3], 19);
        check_eq("pc_timeout", n_timeout, 0);

        // Rise landing exactly on the timeout cycle.
        clear_counts();
        drive_wave(3, 47, 2);
        check_eq("col_nvalid", n_valid, 2);
        check_eq("col_period", meas_period, 49);
        check_eq("col_timeout", n_timeout, 0);

        // Enable drop holds results, no pulses.
        enable = 1'b0;
        clear_counts();
        step(3);
        check_eq("dis_busy", {31'd0, busy}, 0);
        check_eq("dis_period", meas_period, 49);
        check_eq("dis_duty", meas_duty, 3);
        check_eq("dis_pulses", n_valid + n_timeout, 0);

        // Input stuck high.
        pwm_in = 1'b1;
        enable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = timeout;
        end
        check_eq("hi_timeout", {31'd0, seen}, 1);
        check_eq("hi_stuck", {31'd0, stuck_level}, 1);
        check_eq("hi_period", meas_period, 49);
        @(posedge clk);
        #1;

        // Resume with 4 high / 6 low.
        clear_counts();
        pwm_in = 1'b0;
        step(6);
        drive_wave(4, 6, 3);
        check_eq("res_nvalid", n_valid, 2);
        check_eq("res_period", meas_period, 9);
        check_eq("res_duty", meas_duty, 4);
        check_eq("res_timeout", n_timeout, 0);

        // Held low from arming: timeout 50 cycles after ARM is entered.
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        k = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            k++;
            seen = timeout;
        end
        check_eq("lo_latency", k, 52);
        check_eq("lo_stuck", {31'd0, stuck_level}, 0);
        check_eq("lo_period", meas_period, 9);
        @(negedge clk);
        check_eq("lo_pulse1", {31'd0, timeout}, 0);
        check_eq("lo_busy", {31'd0, busy}, 1);
        @(posedge clk);
        #1;

        // Reset mid-period.
        pwm_in = 1'b1;
        step(3);
        pwm_in = 1'b0;
        step(2);
        rst_n = 1'b0;
        step(1);
        check_eq("mr_period", meas_period, 0);
        check_eq("mr_duty", meas_duty, 0);
        check_eq("mr_busy", {31'd0, busy}, 0);
        check_eq("mr_pulses", {30'd0, meas_valid, timeout}, 0);
        rst_n = 1'b1;
        clear_counts();
        step(5);
        drive_wave(3, 7, 2);
        check_eq("mr_nvalid", n_valid, 1);
        check_eq("mr_period2", meas_period, 9);
        check_eq("mr_duty2", meas_duty, 3);
        check_eq("mr_timeout", n_timeout, 0);

        check_eq("no_overlap", tot_both, 0);
        check_eq("pulse_width", tot_wide, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
